// File: rtl/gol_run_sequencer_if.sv
// Control bundle between the HPS PIOs, the run sequencer and the Game of Life engine.
// Handshake: gol_initialize is a level request held while the sequencer is arming a
// generation; the engine answers with the gol_completed level, which the sequencer
// must first see low (fresh generation) and then high (generation finished).
interface gol_run_sequencer_if #(
   parameter int ADDR_W = 12,
   parameter int GEN_W  = 16
) ();
   logic              run_start;
   logic              abort;
   logic [GEN_W-1:0]  run_generations;
   logic              gol_completed;
   logic              gol_initialize;
   logic [ADDR_W-1:0] gol_start_address;
   logic [ADDR_W-1:0] gol_result_address;
   logic              busy;
   logic              done;
   logic              error_timeout;
   logic [GEN_W-1:0]  generations_done;
   logic [ADDR_W-1:0] final_address;
   logic [2:0]        state_dbg;

   // Sequencer side
   modport slave (
      input  run_start, abort, run_generations, gol_completed,
      output gol_initialize, gol_start_address, gol_result_address,
             busy, done, error_timeout, generations_done, final_address, state_dbg
   );

   // HPS / engine / bench side
   modport master (
      output run_start, abort, run_generations, gol_completed,
      input  gol_initialize, gol_start_address, gol_result_address,
             busy, done, error_timeout, generations_done, final_address, state_dbg
   );
endinterface

// File: rtl/gol_run_sequencer.sv
// Runs a programmed number of Game of Life generations back-to-back, ping-ponging
// the source/result boards between two buffers, with abort and timeout handling.
// state_dbg encoding: 0 IDLE, 1 ARM, 2 RUN, 3 STEP, 4 DONE, 5 ERROR.
module gol_run_sequencer #(
   parameter int                ADDR_W         = 12,
   parameter logic [ADDR_W-1:0] BUF_A_BASE     = 12'h000,
   parameter logic [ADDR_W-1:0] BUF_B_BASE     = 12'h800,
   parameter int                GEN_W          = 16,
   parameter int                TIMEOUT_CYCLES = 1000000,
   parameter int                TMO_W          = 20
) (
   input  logic                 fpga_clk_50,
   input  logic                 hps_fpga_reset_n,
   gol_run_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_RUN   = 3'd2,
      S_STEP  = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic              start_prev_q, start_prev_d;
   logic [GEN_W-1:0]  target_q, target_d;
   logic [GEN_W-1:0]  gen_q, gen_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;
   logic [ADDR_W-1:0] result_addr_q, result_addr_d;
   logic [ADDR_W-1:0] final_addr_q, final_addr_d;
   logic              init_q, init_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              start_edge;
   logic [GEN_W-1:0]  gen_inc;

   // Next-state logic; outputs are derived from the next state so they come out registered
   always_comb begin
      state_d       = state_q;
      start_prev_d  = bus.run_start;
      target_d      = target_q;
      gen_d         = gen_q;
      tmo_d         = tmo_q;
      start_addr_d  = start_addr_q;
      result_addr_d = result_addr_q;
      final_addr_d  = final_addr_q;
      start_edge    = bus.run_start & ~start_prev_q;
      gen_inc       = gen_q + 1'b1;

      if (bus.abort) begin
         // Abort wins over everything, including a start edge in the same cycle
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_edge) begin
                  target_d      = bus.run_generations;
                  gen_d         = '0;
                  start_addr_d  = BUF_A_BASE;
                  result_addr_d = BUF_B_BASE;
                  final_addr_d  = BUF_A_BASE;
                  tmo_d         = '0;
                  state_d       = (bus.run_generations == '0) ? S_DONE : S_ARM;
               end
            end
            S_ARM: begin
               // A completed flag still high from the last generation is stale; wait it out
               if (!bus.gol_completed) begin
                  state_d = S_RUN;
                  tmo_d   = '0;
               end else if (tmo_q == TMO_LIMIT) begin
                  state_d = S_ERROR;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            S_RUN: begin
               if (bus.gol_completed) begin
                  state_d = S_STEP;
               end else if (tmo_q == TMO_LIMIT) begin
                  state_d = S_ERROR;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            S_STEP: begin
               gen_d         = gen_inc;
               final_addr_d  = result_addr_q;
               start_addr_d  = result_addr_q;
               result_addr_d = start_addr_q;
               tmo_d         = '0;
               state_d       = (gen_inc == target_q) ? S_DONE : S_ARM;
            end
            default: state_d = S_IDLE;
         endcase
      end

      init_d = (state_d == S_ARM);
      busy_d = (state_d == S_ARM) || (state_d == S_RUN) || (state_d == S_STEP);
      done_d = (state_d == S_DONE);
      err_d  = (state_d == S_ERROR);
   end

   // State and output registers with asynchronous active-low reset
   always_ff @(posedge fpga_clk_50 or negedge hps_fpga_reset_n) begin
      if (!hps_fpga_reset_n) begin
         state_q       <= S_IDLE;
         start_prev_q  <= 1'b0;
         target_q      <= '0;
         gen_q         <= '0;
         tmo_q         <= '0;
         start_addr_q  <= BUF_A_BASE;
         result_addr_q <= BUF_B_BASE;
         final_addr_q  <= BUF_A_BASE;
         init_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_prev_q  <= start_prev_d;
         target_q      <= target_d;
         gen_q         <= gen_d;
         tmo_q         <= tmo_d;
         start_addr_q  <= start_addr_d;
         result_addr_q <= result_addr_d;
         final_addr_q  <= final_addr_d;
         init_q        <= init_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         err_q         <= err_d;
      end
   end

   assign bus.gol_initialize     = init_q;
   assign bus.gol_start_address  = start_addr_q;
   assign bus.gol_result_address = result_addr_q;
   assign bus.busy               = busy_q;
   assign bus.done               = done_q;
   assign bus.error_timeout      = err_q;
   assign bus.generations_done   = gen_q;
   assign bus.final_address      = final_addr_q;
   assign bus.state_dbg          = state_q;

endmodule
